// File: rtl/run_sequencer_if.sv
// Run-driver bundle: operand request, data-memory port, TopLevel start/ack and run status.
// The master side is the run sequencer; the slave side is the environment (memory + core).
// Optional WaitCycles status exists only when RUN_SEQ_CYCLE_COUNT_EN is defined.
interface run_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              Go;
  logic [15:0]       OpA;
  logic [15:0]       OpB;
  logic [ADDR_W-1:0] DmAddr;
  logic              DmWrEn;
  logic [7:0]        DmWrData;
  logic [7:0]        DmRdData;
  logic              CpuStart;
  logic              CpuAck;
  logic              Busy;
  logic              Done;
  logic              Timeout;
  logic [31:0]       Result;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
  logic [15:0]       WaitCycles;
`endif

  modport master (
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    output WaitCycles,
`endif
    input  Go, OpA, OpB, DmRdData, CpuAck,
    output DmAddr, DmWrEn, DmWrData, CpuStart, Busy, Done, Timeout, Result
  );

  modport slave (
`ifdef RUN_SEQ_CYCLE_COUNT_EN
    input  WaitCycles,
`endif
    output Go, OpA, OpB, DmRdData, CpuAck,
    input  DmAddr, DmWrEn, DmWrData, CpuStart, Busy, Done, Timeout, Result
  );
endinterface

// File: rtl/run_sequencer.sv
// Run driver: loads two operands into DM, pulses CpuStart, waits for CpuAck (watchdog), reads 32-bit result.
// Latency: accepted Go -> Done is 4 + START_HOLD + WAIT cycles + 5 + 1; all outputs registered.
// Backpressure: Go is only sampled in IDLE; RUN_SEQ_CYCLE_COUNT_EN adds the WaitCycles status output.
module run_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int LOAD_BASE   = 1,
  parameter int RES_BASE    = 5,
  parameter int START_HOLD  = 1,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic          Clk,
  input  logic          Reset,
  run_sequencer_if.master bus
);

  localparam int HOLD_W = (START_HOLD  > 1) ? $clog2(START_HOLD + 1)  : 1;
  localparam int WD_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] LOAD_ADDR = ADDR_W'(LOAD_BASE);
  localparam logic [ADDR_W-1:0] RES_ADDR  = ADDR_W'(RES_BASE);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    READ  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [2:0]        idx;       // byte index within LOAD / READ
  logic [HOLD_W-1:0] hold_cnt;  // cycles CpuStart has been high
  logic [WD_W-1:0]   wd_cnt;    // watchdog: WAIT cycles without Ack
  logic [31:0]       ops;       // {OpA, OpB} captured on accepted Go
  logic [23:0]       rd_buf;    // first three result bytes, assembled before the single Result load
`ifdef RUN_SEQ_CYCLE_COUNT_EN
  logic [15:0]       wc_run;    // WAIT cycles elapsed in this run, saturating
  logic [15:0]       wc_inc;
  assign wc_inc = (wc_run == 16'hFFFF) ? wc_run : wc_run + 16'd1;
`endif

  // Byte k of the captured operand word, MSB first.
  function automatic logic [7:0] op_byte(input logic [31:0] w, input logic [2:0] k);
    case (k)
      3'd0:    return w[31:24];
      3'd1:    return w[23:16];
      3'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Run-control FSM; every output is a register so reset clears them all asynchronously.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      idx          <= 3'd0;
      hold_cnt     <= '0;
      wd_cnt       <= '0;
      ops          <= 32'd0;
      rd_buf       <= 24'd0;
      bus.DmAddr   <= '0;
      bus.DmWrEn   <= 1'b0;
      bus.DmWrData <= 8'd0;
      bus.CpuStart <= 1'b0;
      bus.Busy     <= 1'b0;
      bus.Done     <= 1'b0;
      bus.Timeout  <= 1'b0;
      bus.Result   <= 32'd0;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
      wc_run         <= 16'd0;
      bus.WaitCycles <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.Go) begin
            ops          <= {bus.OpA, bus.OpB};
            bus.Timeout  <= 1'b0;
            bus.Busy     <= 1'b1;
            idx          <= 3'd0;
            bus.DmWrEn   <= 1'b1;
            bus.DmAddr   <= LOAD_ADDR;
            bus.DmWrData <= bus.OpA[15:8];
            state        <= LOAD;
          end
        end

        LOAD: begin
          if (idx == 3'd3) begin
            bus.DmWrEn   <= 1'b0;
            bus.DmAddr   <= '0;
            bus.DmWrData <= 8'd0;
            bus.CpuStart <= 1'b1;
            hold_cnt     <= '0;
            state        <= START;
          end else begin
            idx          <= idx + 3'd1;
            bus.DmAddr   <= bus.DmAddr + 1'b1;  // wraps modulo 2^ADDR_W
            bus.DmWrData <= op_byte(ops, idx + 3'd1);
          end
        end

        START: begin
          // TopLevel launches on the falling edge of CpuStart.
          if (hold_cnt == HOLD_LAST) begin
            bus.CpuStart <= 1'b0;
            wd_cnt       <= '0;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
            wc_run       <= 16'd0;
`endif
            state        <= WAIT;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        WAIT: begin
`ifdef RUN_SEQ_CYCLE_COUNT_EN
          wc_run <= wc_inc;
`endif
          if (bus.CpuAck) begin
            idx        <= 3'd0;
            bus.DmAddr <= RES_ADDR;
            state      <= READ;
          end else if (wd_cnt == WD_LAST) begin
            // Watchdog expiry ends the run without touching Result.
            bus.Timeout <= 1'b1;
            bus.Done    <= 1'b1;
            bus.Busy    <= 1'b0;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
            bus.WaitCycles <= wc_inc;
`endif
            state       <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end

        READ: begin
          // Address in cycles 0..3, data returns one cycle later (cycles 1..4).
          idx <= idx + 3'd1;
          if (idx < 3'd3) begin
            bus.DmAddr <= bus.DmAddr + 1'b1;
          end else begin
            bus.DmAddr <= '0;
          end
          if (idx != 3'd0 && idx != 3'd4) begin
            rd_buf <= {rd_buf[15:0], bus.DmRdData};
          end
          if (idx == 3'd4) begin
            bus.Result <= {rd_buf, bus.DmRdData};
            bus.Done   <= 1'b1;
            bus.Busy   <= 1'b0;
`ifdef RUN_SEQ_CYCLE_COUNT_EN
            bus.WaitCycles <= wc_run;
`endif
            state      <= DONE;
          end
        end

        DONE: begin
          bus.Done <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          state        <= IDLE;
          bus.DmWrEn   <= 1'b0;
          bus.DmAddr   <= '0;
          bus.CpuStart <= 1'b0;
          bus.Busy     <= 1'b0;
          bus.Done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two instances (default parameters; wrapped bases with short watchdog).
// Stimulus pushes expected DM writes and Done results into queues; a negedge monitor pops and compares.
// A byte-wide synchronous memory model stands in for DM; the bench plays TopLevel via CpuAck.
module tb_run_sequencer;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct packed {
    logic [31:0] res;
    logic        to;
    logic [15:0] wc;
  } dn_t;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  run_sequencer_if #(.ADDR_W(8)) a_if ();
  run_sequencer_if #(.ADDR_W(8)) b_if ();

  run_sequencer #(
    .ADDR_W(8), .LOAD_BASE(1), .RES_BASE(5), .START_HOLD(1), .TIMEOUT_CYC(4096)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(a_if.master)
  );

  run_sequencer #(
    .ADDR_W(8), .LOAD_BASE(254), .RES_BASE(255), .START_HOLD(2), .TIMEOUT_CYC(16)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(b_if.master)
  );

  // DM models: write and registered read share the address; pl_* lets the bench preload result bytes.
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic       pl_en  = 1'b0;
  logic       pl_sel = 1'b0;
  logic [7:0] pl_addr = 8'd0;
  logic [7:0] pl_dat  = 8'd0;

  always @(posedge Clk) begin
    if (a_if.DmWrEn) mem_a[a_if.DmAddr] <= a_if.DmWrData;
    if (b_if.DmWrEn) mem_b[b_if.DmAddr] <= b_if.DmWrData;
    if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_dat;
    if (pl_en &&  pl_sel) mem_b[pl_addr] <= pl_dat;
    a_if.DmRdData <= mem_a[a_if.DmAddr];
    b_if.DmRdData <= mem_b[b_if.DmAddr];
  end

  wr_t qw_a[$];
  wr_t qw_b[$];
  dn_t qd_a[$];
  dn_t qd_b[$];

  int   checks   = 0;
  int   failures = 0;
  int   tmo_cnt  = 0;
  int   sh [2];
  logic rst_chk = 1'b1;
  logic end_req = 1'b0;
  logic end_ack = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic mon(input bit inst);
    string       tag   = inst ? "b_" : "a_";
    logic        wren  = inst ? b_if.DmWrEn   : a_if.DmWrEn;
    logic [7:0]  addr  = inst ? b_if.DmAddr   : a_if.DmAddr;
    logic [7:0]  wdat  = inst ? b_if.DmWrData : a_if.DmWrData;
    logic        busy  = inst ? b_if.Busy     : a_if.Busy;
    logic        to    = inst ? b_if.Timeout  : a_if.Timeout;
    logic        start = inst ? b_if.CpuStart : a_if.CpuStart;
    logic        done  = inst ? b_if.Done     : a_if.Done;
    logic [31:0] res   = inst ? b_if.Result   : a_if.Result;
    int          hold  = inst ? 2 : 1;
    wr_t         ew;
    dn_t         ed;
    int          qn;
    if (wren) begin
      qn = inst ? qw_b.size() : qw_a.size();
      chk({tag, "write_expected"}, 64'(qn != 0), 64'd1);
      if (qn != 0) begin
        ew = inst ? qw_b.pop_front() : qw_a.pop_front();
        chk({tag, "wr_addr"}, 64'(addr), 64'(ew.addr));
        chk({tag, "wr_data"}, 64'(wdat), 64'(ew.data));
        chk({tag, "busy_in_load"}, 64'(busy), 64'd1);
        chk({tag, "timeout_cleared"}, 64'(to), 64'd0);
      end
    end
    if (start) begin
      sh[inst] = sh[inst] + 1;
    end else if (sh[inst] != 0) begin
      chk({tag, "start_hold"}, 64'(sh[inst]), 64'(hold));
      sh[inst] = 0;
    end
    if (done) begin
      qn = inst ? qd_b.size() : qd_a.size();
      chk({tag, "done_expected"}, 64'(qn != 0), 64'd1);
      if (qn != 0) begin
        ed = inst ? qd_b.pop_front() : qd_a.pop_front();
        chk({tag, "result"}, 64'(res), 64'(ed.res));
        chk({tag, "timeout"}, 64'(to), 64'(ed.to));
        chk({tag, "busy_in_done"}, 64'(busy), 64'd0);
        chk({tag, "wren_in_done"}, 64'(wren), 64'd0);
`ifdef RUN_SEQ_CYCLE_COUNT_EN
        chk({tag, "wait_cycles"}, 64'(inst ? b_if.WaitCycles : a_if.WaitCycles), 64'(ed.wc));
`endif
      end
    end
  endtask

  // Monitor: the only process that compares; runs on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    if (!Reset) begin
      sh[0] = 0;
      sh[1] = 0;
      if (rst_chk) begin
        chk("rst_busy",   64'({a_if.Busy, b_if.Busy}), 64'd0);
        chk("rst_start",  64'({a_if.CpuStart, b_if.CpuStart}), 64'd0);
        chk("rst_wren",   64'({a_if.DmWrEn, b_if.DmWrEn}), 64'd0);
        chk("rst_addr",   64'({a_if.DmAddr, b_if.DmAddr}), 64'd0);
        chk("rst_done_to", 64'({a_if.Done, b_if.Done, a_if.Timeout, b_if.Timeout}), 64'd0);
        chk("rst_result", {a_if.Result, b_if.Result}, 64'd0);
      end
    end else begin
      mon(1'b0);
      mon(1'b1);
    end
    if (end_req && !end_ack) begin
      chk("leftover_writes", 64'(qw_a.size() + qw_b.size()), 64'd0);
      chk("leftover_dones",  64'(qd_a.size() + qd_b.size()), 64'd0);
      chk("wait_bounds",     64'(tmo_cnt), 64'd0);
      end_ack = 1'b1;
    end
  end

  function automatic logic start_of(input bit inst);
    return inst ? b_if.CpuStart : a_if.CpuStart;
  endfunction

  function automatic logic done_of(input bit inst);
    return inst ? b_if.Done : a_if.Done;
  endfunction

  task automatic set_in(input bit inst, input logic go, input logic ack);
    if (inst) begin b_if.Go = go; b_if.CpuAck = ack; end
    else      begin a_if.Go = go; a_if.CpuAck = ack; end
  endtask

  task automatic preload(input bit sel, input logic [7:0] addr, input logic [7:0] dat);
    pl_sel = sel; pl_addr = addr; pl_dat = dat; pl_en = 1'b1;
    @(posedge Clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic push_writes(input bit inst, input logic [15:0] opa, input logic [15:0] opb);
    logic [7:0]  base = inst ? 8'd254 : 8'd1;
    logic [31:0] w    = {opa, opb};
    wr_t         e;
    for (int i = 0; i < 4; i++) begin
      e.addr = base + 8'(i);
      e.data = w[8*(3-i) +: 8];
      if (inst) qw_b.push_back(e); else qw_a.push_back(e);
    end
  endtask

  task automatic wait_start_fall(input bit inst);
    int n = 0;
    while (!start_of(inst) && n < 100) begin @(negedge Clk); n++; end
    while (start_of(inst) && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) tmo_cnt++;
  endtask

  task automatic wait_done(input bit inst);
    int n = 0;
    while (!done_of(inst) && n < 300) begin @(negedge Clk); n++; end
    if (n >= 300) tmo_cnt++;
  endtask

  // One complete run; ack arrives n_ack cycles into WAIT, so WAIT lasts n_ack+1 cycles.
  task automatic run(input bit inst, input logic [15:0] opa, input logic [15:0] opb,
                     input bit hold_go, input bit early, input bit expect_to, input int n_ack,
                     input logic [31:0] exp_res, input logic [15:0] exp_wc);
    dn_t d;
    push_writes(inst, opa, opb);
    d.res = exp_res; d.to = expect_to; d.wc = exp_wc;
    if (inst) qd_b.push_back(d); else qd_a.push_back(d);
    if (inst) begin b_if.OpA = opa; b_if.OpB = opb; end
    else      begin a_if.OpA = opa; a_if.OpB = opb; end
    set_in(inst, 1'b1, early);
    @(posedge Clk); #1;
    if (!hold_go) set_in(inst, 1'b0, early);
    if (!expect_to && !early) begin
      wait_start_fall(inst);
      if (n_ack != 0) begin repeat (n_ack) @(posedge Clk); #1; end
      set_in(inst, hold_go, 1'b1);
    end
    wait_done(inst);
    set_in(inst, 1'b0, 1'b0);
    @(posedge Clk); #1;
  endtask

  initial begin
    int n;
    set_in(1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0);
    a_if.OpA = 16'd0; a_if.OpB = 16'd0;
    b_if.OpA = 16'd0; b_if.OpB = 16'd0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    rst_chk = 1'b0;

    // Basic run: ack 20 cycles into WAIT.
    preload(1'b0, 8'd5, 8'h03); preload(1'b0, 8'd6, 8'hFE);
    preload(1'b0, 8'd7, 8'hEC); preload(1'b0, 8'd8, 8'h05);
    run(1'b0, 16'h03FF, 16'hFFFB, 1'b0, 1'b0, 1'b0, 20, 32'h03FEEC05, 16'd21);

    // Early ack: held through LOAD/START, taken on the first WAIT cycle.
    preload(1'b0, 8'd5, 8'hDE); preload(1'b0, 8'd6, 8'hAD);
    preload(1'b0, 8'd7, 8'hBE); preload(1'b0, 8'd8, 8'hEF);
    run(1'b0, 16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 0, 32'hDEADBEEF, 16'd1);

    // Go held for the whole run: exactly one run's worth of writes and Done.
    preload(1'b0, 8'd5, 8'h11); preload(1'b0, 8'd6, 8'h22);
    preload(1'b0, 8'd7, 8'h33); preload(1'b0, 8'd8, 8'h44);
    run(1'b0, 16'hAAAA, 16'h5555, 1'b1, 1'b0, 1'b0, 3, 32'h11223344, 16'd4);
    repeat (20) @(posedge Clk);
    #1;

    // Wrapped bases: loads at 254,255,0,1; result read from 255,0,1,2.
    preload(1'b1, 8'd2, 8'h5A);
    run(1'b1, 16'hA1B2, 16'hC3D4, 1'b0, 1'b0, 1'b0, 2, 32'hB2C3D45A, 16'd3);

    // Watchdog: no ack, Result keeps the previous value, Timeout set.
    run(1'b1, 16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, 0, 32'hB2C3D45A, 16'd16);

    // Next run clears Timeout (checked on every LOAD write) and completes normally.
    run(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0, 0, 32'h0203045A, 16'd1);

    // Reset in the middle of WAIT: everything drops in the same cycle.
    push_writes(1'b0, 16'hCAFE, 16'hBEEF);
    a_if.OpA = 16'hCAFE; a_if.OpB = 16'hBEEF;
    set_in(1'b0, 1'b1, 1'b0);
    @(posedge Clk); #1;
    set_in(1'b0, 1'b0, 1'b0);
    wait_start_fall(1'b0);
    repeat (5) @(posedge Clk);
    #1 Reset = 1'b0;
    rst_chk = 1'b1;
    @(negedge Clk);
    @(posedge Clk);
    #1 Reset = 1'b1;
    rst_chk = 1'b0;

    // Clean restart after reset.
    preload(1'b0, 8'd5, 8'h0A); preload(1'b0, 8'd6, 8'h0B);
    preload(1'b0, 8'd7, 8'h0C); preload(1'b0, 8'd8, 8'h0D);
    run(1'b0, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 5, 32'h0A0B0C0D, 16'd6);

    end_req = 1'b1;
    n = 0;
    while (!end_ack && n < 10) begin @(posedge Clk); n++; end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
